// File: rtl/edge_capture_if.sv
// edge_capture_if
//   Bundles the channel inputs, arm/ack controls and event outputs of
//   edge_capture so the block and its driver share one port.
//   master : drives I_signal, I_mode, I_ack; observes all O_* outputs
//   slave  : edge_capture side (inputs in, outputs out)
//   Parameter CHANNELS sets the width of every per-channel vector.
interface edge_capture_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0]   I_signal;   // raw channel inputs
  logic [2*CHANNELS-1:0] I_mode;     // per-channel arm mode {fall, rise}
  logic [CHANNELS-1:0]   I_ack;      // per-channel pending clear
  logic [CHANNELS-1:0]   O_level;    // filtered channel level
  logic [CHANNELS-1:0]   O_rise;     // one-cycle rise pulse
  logic [CHANNELS-1:0]   O_fall;     // one-cycle fall pulse
  logic [CHANNELS-1:0]   O_pending;  // sticky, mode-masked event flag
  logic                  O_any;      // OR of O_pending

  modport master (
    output I_signal, I_mode, I_ack,
    input  O_level, O_rise, O_fall, O_pending, O_any
  );

  modport slave (
    input  I_signal, I_mode, I_ack,
    output O_level, O_rise, O_fall, O_pending, O_any
  );
endinterface

// File: rtl/edge_capture.sv
// edge_capture
//   Multi-channel edge detector and event latch. Per channel:
//   optional synchroniser -> stability filter -> level register ->
//   rise/fall pulses and a sticky pending flag armed by I_mode.
//
//   Parameters
//     CHANNELS    : number of independent channels (>=1)
//     SYNC_STAGES : synchroniser depth (>=2), only with EDGE_CAPTURE_SYNC_EN
//     FILTER_LEN  : clocks a new level must persist before it is accepted
//
//   Ports
//     I_clock : clock, rising edge
//     I_reset : asynchronous active-low reset
//     bus     : edge_capture_if.slave (I_signal, I_mode, I_ack in;
//               O_level, O_rise, O_fall, O_pending, O_any out)
//
//   Build option
//     EDGE_CAPTURE_SYNC_EN defined  : inputs pass through a SYNC_STAGES flop
//                                     chain (asynchronous pins).
//     EDGE_CAPTURE_SYNC_EN undefined: filter samples I_signal directly.
module edge_capture #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 1
) (
  input  logic           I_clock,
  input  logic           I_reset,
  edge_capture_if.slave  bus
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [CHANNELS-1:0] level_vec;
  logic [CHANNELS-1:0] rise_vec;
  logic [CHANNELS-1:0] fall_vec;
  logic [CHANNELS-1:0] pend_vec;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic          filt_in;
    logic [CW-1:0] cnt_reg;
    logic          level_reg;
    logic          rise_reg;
    logic          fall_reg;
    logic          pend_reg;
    logic          toggle;
    logic          arm_rise;
    logic          arm_fall;
    logic          set_pend;

`ifdef EDGE_CAPTURE_SYNC_EN
    logic [SYNC_STAGES-1:0] sync_reg;

    always_ff @(posedge I_clock or negedge I_reset) begin
      if (!I_reset) begin
        sync_reg <= '0;
      end else begin
        sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.I_signal[gi]};
      end
    end

    assign filt_in = sync_reg[SYNC_STAGES-1];
`else
    assign filt_in = bus.I_signal[gi];
`endif

    // The counter holds the number of edges the new level has already been
    // seen; the edge that would make it FILTER_LEN toggles the level instead.
    assign toggle   = (filt_in != level_reg) && (cnt_reg == CW'(FILTER_LEN - 1));
    assign arm_rise = bus.I_mode[2*gi];
    assign arm_fall = bus.I_mode[2*gi+1];
    // level_reg is the pre-toggle level, so 0 means this toggle is a rise.
    assign set_pend = toggle && ((!level_reg && arm_rise) || (level_reg && arm_fall));

    always_ff @(posedge I_clock or negedge I_reset) begin
      if (!I_reset) begin
        cnt_reg   <= '0;
        level_reg <= 1'b0;
        rise_reg  <= 1'b0;
        fall_reg  <= 1'b0;
        pend_reg  <= 1'b0;
      end else begin
        if ((filt_in == level_reg) || toggle) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
        level_reg <= level_reg ^ toggle;
        rise_reg  <= toggle && !level_reg;
        fall_reg  <= toggle && level_reg;
        // A new set beats a simultaneous acknowledge.
        pend_reg  <= set_pend || (pend_reg && !bus.I_ack[gi]);
      end
    end

    assign level_vec[gi] = level_reg;
    assign rise_vec[gi]  = rise_reg;
    assign fall_vec[gi]  = fall_reg;
    assign pend_vec[gi]  = pend_reg;
  end

  assign bus.O_level   = level_vec;
  assign bus.O_rise    = rise_vec;
  assign bus.O_fall    = fall_vec;
  assign bus.O_pending = pend_vec;
  assign bus.O_any     = |pend_vec;

endmodule
